iter_comparator: RTL and testbench
==================================

Name: iter_comparator

Overview:
Parametrised, sequential successor to the team's 8-bit combinational magnitude comparator. It compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and terminates early at the first differing chunk. It supports unsigned and signed (two's-complement) modes and uses a start/ready/valid handshake. It sits beside the ALU datapath and keeps the legacy y_out/carry/zero result encoding so existing consumers stay unchanged.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of CHUNK (elaboration error otherwise).
CHUNK, 2, bits compared per cycle; 1..WIDTH.
NCHUNK, WIDTH/CHUNK, derived local parameter; not overridable.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when ready=1
signed_mode  in  1  0=unsigned, 1=two's-complement; sampled with start
a_in  in  WIDTH  operand A; sampled with start
b_in  in  WIDTH  operand B; sampled with start
abort  in  1  cancels an operation in progress
ready  out  1  idle, able to accept start
valid  out  1  one-cycle pulse: result registers updated this cycle
lt  out  1  A<B
gt  out  1  A>B
eq  out  1  A==B
y_out  out  WIDTH  legacy encoding: lt -> 1, gt -> 1<<(WIDTH-1), eq -> 0
carry  out  1  legacy borrow flag, equal to lt
zero  out  1  legacy zero flag, equal to eq

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ready=1, valid=0, lt=gt=eq=0, y_out=0, carry=0, zero=0, idx=0, operand registers 0.
- States: IDLE, RUN.
- IDLE: ready=1.
  - start=1 at an edge: capture a_in, b_in and signed_mode, set idx=0, go to RUN. ready=0 from the next cycle.
- RUN: ready=0. Each edge compares chunk idx, counted from the MSB (idx 0 = bits WIDTH-1 down to WIDTH-CHUNK).
  - Signed mode: the MSB of chunk 0 is inverted on both operands before the compare. All chunks compare unsigned.
  - Chunk differs: set lt/gt from that chunk, eq=0, pulse valid, go to IDLE.
  - Chunk equal and idx==NCHUNK-1: eq=1, lt=gt=0, pulse valid, go to IDLE.
  - Chunk equal and idx<NCHUNK-1: idx increments, stay in RUN.
- Latency: valid rises k edges after the start edge. k = 1 + index of the first differing chunk, or NCHUNK if the operands are equal. Range 1..NCHUNK.
- Exactly one of lt/gt/eq is 1 after any completed operation.
- y_out, carry and zero are updated in the same edge as lt/gt/eq and are consistent with them.
- Results hold until the next valid or reset. valid is high for exactly one cycle.
- ready returns to 1 in the same cycle valid is high. A start in that cycle is accepted (back-to-back, no bubble).
- start while ready=0 is ignored, not queued.
- abort=1 in RUN: return to IDLE at the next edge. No valid pulse; result outputs keep their previous values.
- abort in IDLE: no effect.
- abort and completion at the same edge: abort wins, so no valid pulse.
- rst_n asserted mid-operation: immediate return to reset values. No valid pulse.
- Operand inputs may change freely after the start edge; only the captured copies are used.

Decomposition:
- Shared package iter_cmp_pkg holds:
  - state enum {IDLE, RUN}
  - result-encoding constants: Y_LT = 1, Y_GT = MSB-only pattern built from WIDTH, Y_EQ = 0
- One combinational sub-module cmp_chunk (CHUNK-bit unsigned compare, outputs lt/gt).
  - Instantiated once and fed the muxed chunk selected by idx, with the signed MSB inversion applied when idx==0.

Test Plan (WIDTH=8, CHUNK=2 unless noted):
1. Unsigned a=0x12, b=0x34 -> chunk0 equal, chunk1 01<11. valid 2 edges after start; lt=1, y_out=0x01, carry=1, zero=0.
2. a=b=0xA5, either mode -> valid after 4 edges; eq=1, zero=1, y_out=0x00, lt=gt=0.
3. Sign-sensitive, a=0x80, b=0x01:
   - signed_mode=0 -> gt=1, y_out=0x80, valid after 1 edge.
   - signed_mode=1 -> lt=1, y_out=0x01, valid after 1 edge.
4. Back-to-back: start held high across the valid cycle with new operands a=0xFF, b=0xFE -> second operation accepted with no idle cycle. gt after 4 edges; the first result stays visible until then.
5. Abort and reset:
   - abort on the second RUN edge of a=b=0x55 -> no valid, outputs unchanged, ready=1 next cycle.
   - rst_n low mid-RUN -> all outputs 0 and ready=1 asynchronously.
6. WIDTH=16, CHUNK=4: random signed/unsigned sweep of 10k operand pairs, checked against a reference model -> one-hot lt/gt/eq, and latency equals 1 + first differing nibble index (4 when equal).

Source files
------------

// File: rtl/iter_cmp_pkg.sv
// Shared types and legacy result-encoding constants for the iterative comparator.
package iter_cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Legacy y_out encoding: less-than reports 1, equal reports 0.
  localparam int Y_LT = 1;
  localparam int Y_EQ = 0;

  // Greater-than reports the MSB-only pattern of the operand width.
  function automatic logic [63:0] y_gt_pat(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/iter_comparator_cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk
  import iter_cmp_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/iter_comparator.sv
// Sequential MSB-first magnitude comparator, CHUNK bits per clock, with early
// exit on the first differing chunk and the legacy y_out/carry/zero encoding.
module iter_comparator
  import iter_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             abort,
  output logic             ready,
  output logic             valid,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [WIDTH-1:0] y_out,
  output logic             carry,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] Y_GT     = WIDTH'(y_gt_pat(WIDTH));

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("iter_comparator: WIDTH must be a positive multiple of CHUNK");
  end
  if (WIDTH > 64) begin : g_bad_width
    $error("iter_comparator: WIDTH above 64 is not supported");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic [IDXW-1:0]  idx;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic             c_lt, c_gt;

  // Select chunk idx (MSB first); signed mode flips the sign bit of chunk 0 so
  // an unsigned compare orders two's-complement values correctly.
  always_comb begin
    a_sh = a_q << (int'(idx) * CHUNK);
    b_sh = b_q << (int'(idx) * CHUNK);
    a_ch = a_sh[WIDTH-1 -: CHUNK];
    b_ch = b_sh[WIDTH-1 -: CHUNK];
    if (sm_q && idx == '0) begin
      a_ch[CHUNK-1] = ~a_ch[CHUNK-1];
      b_ch[CHUNK-1] = ~b_ch[CHUNK-1];
    end
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
    .a  (a_ch),
    .b  (b_ch),
    .lt (c_lt),
    .gt (c_gt)
  );

  // Control FSM with registered handshake and result outputs; abort wins over
  // a completion on the same edge, and results hold until the next valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      y_out <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            sm_q  <= signed_mode;
            idx   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            ready <= 1'b1;
            state <= IDLE;
          end else if (c_lt || c_gt) begin
            lt    <= c_lt;
            gt    <= c_gt;
            eq    <= 1'b0;
            y_out <= c_lt ? WIDTH'(Y_LT) : Y_GT;
            carry <= c_lt;
            zero  <= 1'b0;
            valid <= 1'b1;
            ready <= 1'b1;
            state <= IDLE;
          end else if (idx == LAST_IDX) begin
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b1;
            y_out <= WIDTH'(Y_EQ);
            carry <= 1'b0;
            zero  <= 1'b1;
            valid <= 1'b1;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_comparator.sv
// Bench for iter_comparator: directed handshake/abort/reset cases on an 8/2
// instance and a randomized sweep on a 16/4 instance, scored against a
// value-level reference model through per-instance expectation queues.
module tb_iter_comparator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          lt, gt, eq, carry, zero;
    logic [63:0] y;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t last8;
  exp_t e8, e16;

  // 8-bit / 2-bit-chunk instance
  logic       s8_start = 1'b0, s8_sm = 1'b0, s8_abort = 1'b0;
  logic [7:0] s8_a = '0, s8_b = '0;
  logic       r8_ready, r8_valid, r8_lt, r8_gt, r8_eq, r8_carry, r8_zero;
  logic [7:0] r8_y;

  // 16-bit / 4-bit-chunk instance
  logic        s16_start = 1'b0, s16_sm = 1'b0, s16_abort = 1'b0;
  logic [15:0] s16_a = '0, s16_b = '0;
  logic        r16_ready, r16_valid, r16_lt, r16_gt, r16_eq, r16_carry, r16_zero;
  logic [15:0] r16_y;

  iter_comparator #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .signed_mode(s8_sm),
    .a_in(s8_a), .b_in(s8_b), .abort(s8_abort),
    .ready(r8_ready), .valid(r8_valid), .lt(r8_lt), .gt(r8_gt), .eq(r8_eq),
    .y_out(r8_y), .carry(r8_carry), .zero(r8_zero)
  );

  iter_comparator #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16_start), .signed_mode(s16_sm),
    .a_in(s16_a), .b_in(s16_b), .abort(s16_abort),
    .ready(r16_ready), .valid(r16_valid), .lt(r16_lt), .gt(r16_gt), .eq(r16_eq),
    .y_out(r16_y), .carry(r16_carry), .zero(r16_zero)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: compare the operands as numbers; latency from the first
  // differing CHUNK-wide digit counted from the top.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input bit sm, input int w, input int c);
    exp_t e;
    logic signed [63:0] sa, sb;
    logic [63:0] mask;
    bit a_lt, a_gt;
    if (sm) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      a_lt = (sa < sb);
      a_gt = (sa > sb);
    end else begin
      a_lt = (a < b);
      a_gt = (a > b);
    end
    e.lt = a_lt; e.gt = a_gt; e.eq = !a_lt && !a_gt;
    e.carry = a_lt; e.zero = e.eq;
    e.y = a_lt ? 64'd1 : (a_gt ? (64'd1 << (w - 1)) : 64'd0);
    mask = (64'd1 << c) - 64'd1;
    e.lat = w / c;
    for (int i = w / c - 1; i >= 0; i--) begin
      int sh;
      sh = w - c * (i + 1);
      if (((a >> sh) & mask) != ((b >> sh) & mask)) e.lat = i + 1;
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input bit lt, input bit gt,
                       input bit eq, input bit carry, input bit zero, input logic [63:0] y);
    chk({tag, " flags"}, 64'({lt, gt, eq, carry, zero}),
        64'({e.lt, e.gt, e.eq, e.carry, e.zero}));
    chk({tag, " y_out"}, y, e.y);
    chk({tag, " latency"}, 64'(cyc - e.acc), 64'(e.lat));
    chk({tag, " one-hot"}, 64'($countones({lt, gt, eq})), 64'd1);
  endtask

  // Monitors: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && r8_valid) begin
      if (q8.size() == 0) chk("dut8 valid without request", 64'(r8_valid), 64'd0);
      else begin
        e8 = q8.pop_front();
        score("dut8", e8, r8_lt, r8_gt, r8_eq, r8_carry, r8_zero, 64'(r8_y));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && r16_valid) begin
      if (q16.size() == 0) chk("dut16 valid without request", 64'(r16_valid), 64'd0);
      else begin
        e16 = q16.pop_front();
        score("dut16", e16, r16_lt, r16_gt, r16_eq, r16_carry, r16_zero, 64'(r16_y));
      end
    end
  end

  task automatic wait_ready8();
    int n = 0;
    do begin @(negedge clk); n++; end while (!r8_ready && n < 50);
    if (!r8_ready) chk("dut8 ready timeout", 64'(r8_ready), 64'd1);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (q8.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (q8.size() != 0) chk("dut8 result timeout", 64'(q8.size()), 64'd0);
  endtask

  // Called at a negedge with ready high; returns #1 after the accepting edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input bit sm, input bit push);
    exp_t e;
    s8_a = a; s8_b = b; s8_sm = sm; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    if (push) begin
      e = model(64'(a), 64'(b), sm, 8, 2);
      e.acc = cyc;
      q8.push_back(e);
      last8 = e;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sm);
    wait_ready8();
    start8(a, b, sm, 1'b1);
    wait_done8();
  endtask

  task automatic chk_hold8(input string name);
    chk({name, " valid"}, 64'(r8_valid), 64'd0);
    chk({name, " ready"}, 64'(r8_ready), 64'd1);
    chk({name, " held result"}, 64'({r8_lt, r8_gt, r8_eq, r8_carry, r8_zero, r8_y}),
        64'({last8.lt, last8.gt, last8.eq, last8.carry, last8.zero, last8.y[7:0]}));
  endtask

  task automatic wait_ready16();
    int n = 0;
    do begin @(negedge clk); n++; end while (!r16_ready && n < 50);
    if (!r16_ready) chk("dut16 ready timeout", 64'(r16_ready), 64'd1);
  endtask

  task automatic start16(input logic [15:0] a, input logic [15:0] b, input bit sm);
    exp_t e;
    s16_a = a; s16_b = b; s16_sm = sm; s16_start = 1'b1;
    @(posedge clk); #1;
    s16_start = 1'b0;
    e = model(64'(a), 64'(b), sm, 16, 4);
    e.acc = cyc;
    q16.push_back(e);
  endtask

  initial begin
    exp_t e1, e2;
    logic [15:0] ra, rb;
    int n;

    last8 = '{default: 0};
    rst_n = 1'b0;
    #12;
    chk("reset dut8", 64'({r8_ready, r8_valid, r8_lt, r8_gt, r8_eq, r8_carry, r8_zero, r8_y}),
        64'({1'b1, 6'b0, 8'h00}));
    chk("reset dut16", 64'({r16_ready, r16_valid, r16_lt, r16_gt, r16_eq, r16_y}),
        64'({1'b1, 4'b0, 16'h0000}));
    @(negedge clk); rst_n = 1'b1;

    run8(8'h12, 8'h34, 1'b0);
    run8(8'hA5, 8'hA5, 1'b0);
    run8(8'hA5, 8'hA5, 1'b1);
    run8(8'h80, 8'h01, 1'b0);
    run8(8'h80, 8'h01, 1'b1);

    // abort while idle does nothing
    @(negedge clk); s8_abort = 1'b1;
    @(negedge clk); s8_abort = 1'b0;
    chk_hold8("idle abort");

    // back-to-back: start held across the valid cycle with new operands
    wait_ready8();
    s8_a = 8'h12; s8_b = 8'h34; s8_sm = 1'b0; s8_start = 1'b1;
    @(posedge clk); #1;
    e1 = model(64'h12, 64'h34, 1'b0, 8, 2); e1.acc = cyc; q8.push_back(e1);
    @(negedge clk); s8_a = 8'hFF; s8_b = 8'hFE;
    n = 0;
    while (!r8_valid && n < 20) begin @(negedge clk); n++; end
    chk("b2b ready with valid", 64'({r8_valid, r8_ready}), 64'b11);
    @(posedge clk); #1;
    s8_start = 1'b0;
    e2 = model(64'hFF, 64'hFE, 1'b0, 8, 2); e2.acc = cyc; q8.push_back(e2); last8 = e2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b first result held", 64'({r8_lt, r8_gt, r8_eq, r8_y}),
          64'({e1.lt, e1.gt, e1.eq, e1.y[7:0]}));
    end
    wait_done8();

    // start while busy is ignored
    wait_ready8();
    start8(8'hA5, 8'hA5, 1'b0, 1'b1);
    @(negedge clk); s8_a = 8'h00; s8_b = 8'hFF; s8_start = 1'b1;
    @(negedge clk); s8_start = 1'b0;
    wait_done8();
    repeat (3) @(negedge clk);

    // abort on the second RUN edge
    wait_ready8();
    start8(8'h55, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); s8_abort = 1'b1;
    @(negedge clk); s8_abort = 1'b0;
    chk_hold8("abort mid-run");
    repeat (4) @(negedge clk);
    chk_hold8("abort no late valid");

    // abort coincides with a one-edge completion
    wait_ready8();
    start8(8'h80, 8'h01, 1'b0, 1'b0);
    s8_abort = 1'b1;
    @(negedge clk);
    @(negedge clk); s8_abort = 1'b0;
    chk_hold8("abort vs completion");

    // asynchronous reset mid-run
    wait_ready8();
    start8(8'h55, 8'h55, 1'b0, 1'b0);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("async reset mid-run", 64'({r8_ready, r8_valid, r8_lt, r8_gt, r8_eq, r8_carry, r8_zero, r8_y}),
        64'({1'b1, 6'b0, 8'h00}));
    @(negedge clk); rst_n = 1'b1;
    last8 = '{default: 0};
    run8(8'h34, 8'h12, 1'b0);

    // randomized sweep on the wide instance, biased toward late differences
    for (int k = 0; k < 10000; k++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'($urandom);
        1: rb = ra;
        default: rb = ra ^ 16'((($urandom & 32'hF)) << (4 * $urandom_range(0, 3)));
      endcase
      wait_ready16();
      start16(ra, rb, 1'($urandom));
    end

    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin @(negedge clk); n++; end
    chk("dut8 drained", 64'(q8.size()), 64'd0);
    chk("dut16 drained", 64'(q16.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
